// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush bubble and bubble counter
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             ALUSrc_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [9:0]       funct_i,
    input  logic [XLEN-1:0]  RS1data_i,
    input  logic [XLEN-1:0]  RS2data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic [4:0]       RDaddr_i,
    output logic             valid_o,
    output logic             RegWrite_o,
    output logic             MemtoReg_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             ALUSrc_o,
    output logic [1:0]       ALUOp_o,
    output logic [9:0]       funct_o,
    output logic [XLEN-1:0]  RS1data_o,
    output logic [XLEN-1:0]  RS2data_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       RS1addr_o,
    output logic [4:0]       RS2addr_o,
    output logic [4:0]       RDaddr_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic             r_valid;
    logic             r_regwrite;
    logic             r_memtoreg;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_alusrc;
    logic [1:0]       r_aluop;
    logic [9:0]       r_funct;
    logic [XLEN-1:0]  r_rs1data;
    logic [XLEN-1:0]  r_rs2data;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1addr;
    logic [4:0]       r_rs2addr;
    logic [4:0]       r_rdaddr;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_bubble;
    logic w_cnt_sat;

    // A bubble enters the slot on a flush, or on a load of an empty ID slot.
    assign w_bubble  = flush_i | (~stall_i & ~valid_i);
    assign w_cnt_sat = &r_bubble_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= '0;
            r_funct    <= '0;
            r_rs1data  <= '0;
            r_rs2data  <= '0;
            r_imm      <= '0;
            r_rs1addr  <= '0;
            r_rs2addr  <= '0;
            r_rdaddr   <= '0;
        end else if (flush_i) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= '0;
            r_funct    <= '0;
            r_rs1data  <= '0;
            r_rs2data  <= '0;
            r_imm      <= '0;
            r_rs1addr  <= '0;
            r_rs2addr  <= '0;
            r_rdaddr   <= '0;
        end else if (!stall_i) begin
            // Side-effecting controls are masked so a bubble can never write state.
            r_valid    <= valid_i;
            r_regwrite <= RegWrite_i & valid_i;
            r_memread  <= MemRead_i & valid_i;
            r_memwrite <= MemWrite_i & valid_i;
            r_memtoreg <= MemtoReg_i;
            r_alusrc   <= ALUSrc_i;
            r_aluop    <= ALUOp_i;
            r_funct    <= funct_i;
            r_rs1data  <= RS1data_i;
            r_rs2data  <= RS2data_i;
            r_imm      <= imm_i;
            r_rs1addr  <= RS1addr_i;
            r_rs2addr  <= RS2addr_i;
            r_rdaddr   <= RDaddr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign valid_o      = r_valid;
    assign RegWrite_o   = r_regwrite;
    assign MemtoReg_o   = r_memtoreg;
    assign MemRead_o    = r_memread;
    assign MemWrite_o   = r_memwrite;
    assign ALUSrc_o     = r_alusrc;
    assign ALUOp_o      = r_aluop;
    assign funct_o      = r_funct;
    assign RS1data_o    = r_rs1data;
    assign RS2data_o    = r_rs2data;
    assign imm_o        = r_imm;
    assign RS1addr_o    = r_rs1addr;
    assign RS2addr_o    = r_rs2addr;
    assign RDaddr_o     = r_rdaddr;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - vector table, corner sequences and random model check for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [9:0]  funct;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rda;
    } slot_t;

    typedef struct {
        logic        flush;
        logic        stall;
        logic        valid;
        logic        rw;
        logic        mw;
        logic [31:0] rs1;
        logic        e_valid;
        logic        e_rw;
        logic        e_mw;
        logic [31:0] e_rs1;
        int          e_cnt;
    } vec_t;

    logic clk;
    logic rst;
    logic stall;
    logic flush;
    slot_t cur;
    slot_t act;
    slot_t act_s;
    logic [31:0] cnt_big;
    logic [3:0]  cnt_small;

    slot_t       m_slot;
    longint      m_cnt;
    int          m_cnt_small;
    int          checks;
    int          failures;
    vec_t        vecs [10];

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(cur.valid),
        .RegWrite_i(cur.regwrite), .MemtoReg_i(cur.memtoreg), .MemRead_i(cur.memread),
        .MemWrite_i(cur.memwrite), .ALUSrc_i(cur.alusrc), .ALUOp_i(cur.aluop), .funct_i(cur.funct),
        .RS1data_i(cur.rs1d), .RS2data_i(cur.rs2d), .imm_i(cur.imm),
        .RS1addr_i(cur.rs1a), .RS2addr_i(cur.rs2a), .RDaddr_i(cur.rda),
        .valid_o(act.valid), .RegWrite_o(act.regwrite), .MemtoReg_o(act.memtoreg),
        .MemRead_o(act.memread), .MemWrite_o(act.memwrite), .ALUSrc_o(act.alusrc),
        .ALUOp_o(act.aluop), .funct_o(act.funct), .RS1data_o(act.rs1d), .RS2data_o(act.rs2d),
        .imm_o(act.imm), .RS1addr_o(act.rs1a), .RS2addr_o(act.rs2a), .RDaddr_o(act.rda),
        .bubble_cnt_o(cnt_big)
    );

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(4)) u_dut_small (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(cur.valid),
        .RegWrite_i(cur.regwrite), .MemtoReg_i(cur.memtoreg), .MemRead_i(cur.memread),
        .MemWrite_i(cur.memwrite), .ALUSrc_i(cur.alusrc), .ALUOp_i(cur.aluop), .funct_i(cur.funct),
        .RS1data_i(cur.rs1d), .RS2data_i(cur.rs2d), .imm_i(cur.imm),
        .RS1addr_i(cur.rs1a), .RS2addr_i(cur.rs2a), .RDaddr_i(cur.rda),
        .valid_o(act_s.valid), .RegWrite_o(act_s.regwrite), .MemtoReg_o(act_s.memtoreg),
        .MemRead_o(act_s.memread), .MemWrite_o(act_s.memwrite), .ALUSrc_o(act_s.alusrc),
        .ALUOp_o(act_s.aluop), .funct_o(act_s.funct), .RS1data_o(act_s.rs1d), .RS2data_o(act_s.rs2d),
        .imm_o(act_s.imm), .RS1addr_o(act_s.rs1a), .RS2addr_o(act_s.rs2a), .RDaddr_o(act_s.rda),
        .bubble_cnt_o(cnt_small)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [128:0] a, input logic [128:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, a, e);
        end
    endtask

    // Reference: the slot is either cleared, kept, or replaced by the masked ID bundle.
    task automatic model_edge();
        if (flush) begin
            m_slot = '0;
        end else if (!stall) begin
            m_slot = cur;
            if (!cur.valid) begin
                m_slot.regwrite = 1'b0;
                m_slot.memread  = 1'b0;
                m_slot.memwrite = 1'b0;
            end
        end
        if (flush || (!stall && !cur.valid)) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt_small < 15) m_cnt_small++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic model_reset();
        m_slot = '0;
        m_cnt = 0;
        m_cnt_small = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_slot"}, 129'(act), 129'(m_slot));
        check({tag, "_slot_small"}, 129'(act_s), 129'(m_slot));
        check({tag, "_cnt"}, 129'(cnt_big), 129'(m_cnt));
        check({tag, "_cnt_small"}, 129'(cnt_small), 129'(m_cnt_small));
    endtask

    task automatic randomize_inputs();
        cur.valid    = 1'($urandom);
        cur.regwrite = 1'($urandom);
        cur.memtoreg = 1'($urandom);
        cur.memread  = 1'($urandom);
        cur.memwrite = 1'($urandom);
        cur.alusrc   = 1'($urandom);
        cur.aluop    = 2'($urandom);
        cur.funct    = 10'($urandom);
        cur.rs1d     = $urandom;
        cur.rs2d     = $urandom;
        cur.imm      = $urandom;
        cur.rs1a     = 5'($urandom);
        cur.rs2a     = 5'($urandom);
        cur.rda      = 5'($urandom);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0000_0005, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 2};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b1, 32'h0000_00AA, 2};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00BB, 1'b1, 1'b0, 1'b1, 32'h0000_00AA, 2};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00CC, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 3};

        // Reset from power-up with every input nonzero.
        rst   = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        cur   = '1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // Vector table.
        cur       = '0;
        cur.aluop = 2'b10;
        cur.funct = 10'h000;
        cur.rs2d  = 32'hFFFF_FFFD;
        cur.rda   = 5'd7;
        for (int i = 0; i < 10; i++) begin
            flush        = vecs[i].flush;
            stall        = vecs[i].stall;
            cur.valid    = vecs[i].valid;
            cur.regwrite = vecs[i].rw;
            cur.memwrite = vecs[i].mw;
            cur.rs1d     = vecs[i].rs1;
            step();
            check($sformatf("vec%0d_valid", i), 129'(act.valid), 129'(vecs[i].e_valid));
            check($sformatf("vec%0d_regwrite", i), 129'(act.regwrite), 129'(vecs[i].e_rw));
            check($sformatf("vec%0d_memwrite", i), 129'(act.memwrite), 129'(vecs[i].e_mw));
            check($sformatf("vec%0d_rs1data", i), 129'(act.rs1d), 129'(vecs[i].e_rs1));
            check($sformatf("vec%0d_cnt", i), 129'(cnt_big), 129'(vecs[i].e_cnt));
            if (i == 0) begin
                check("load_aluop", 129'(act.aluop), 129'(2'b10));
                check("load_rs2data", 129'(act.rs2d), 129'(32'hFFFF_FFFD));
                check("load_rdaddr", 129'(act.rda), 129'(5'd7));
            end
        end
        check_all("table_end");

        // Mid-cycle asynchronous reset with nonzero contents and inputs.
        flush = 1'b0;
        stall = 1'b0;
        cur   = '1;
        step();
        check_all("pre_reset");
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        rst = 1'b0;

        // Counter saturation on the 4-bit instance.
        flush = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("sat_small_%0d", k), 129'(cnt_small), 129'((k > 15) ? 15 : k));
            check($sformatf("sat_big_%0d", k), 129'(cnt_big), 129'(k));
        end
        flush = 1'b0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step();
            check_all($sformatf("rand%0d", n));
            if (!act.valid)
                check($sformatf("rand%0d_bubble_inert", n),
                      129'({act.regwrite, act.memread, act.memwrite}), 129'(3'b000));
        end

        // Reset asserted while stall and flush are both held.
        stall = 1'b1;
        flush = 1'b1;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid_stall");
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
